harmonic_mixer: RTL and testbench

- Consumer end of the per-harmonic sample handshake. Once per output sample, it walks the harmonic index and takes each harmonic's sine sample from the sample-position block.
- Each sample is weighted by a geometrically decaying amplitude and summed into an accumulator.
- Emits one saturated 16-bit mixed sample per frame to the DAC path.
- Also retires the harmonic index back to 0 at frame end, so the producer restarts its frequency accumulation.

---
 rtl/harmonic_mixer.sv | 174 +++++++++++++++++
 tb/tb_harmonic_mixer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/harmonic_mixer.sv
// Harmonic mixer: walks the harmonic index, weights each producer sample by a
// geometrically decaying amplitude, and emits one saturated mixed sample per frame.
module harmonic_mixer #(
  parameter int unsigned OUT_SHIFT = 2,
  parameter int unsigned ACC_W     = 25
) (
  input  logic        i_Clock,
  input  logic        i_Reset_n,
  input  logic        i_Start,
  input  logic [7:0]  i_Harmonic_Count,
  input  logic [15:0] i_Decay,
  input  logic        i_Sample_Ready,
  input  logic [15:0] i_Sample_Value,
  input  logic        i_Freq_Too_High,
  output logic [7:0]  o_Harmonic,
  output logic        o_Next_Sample,
  output logic [15:0] o_Mix_Out,
  output logic        o_Mix_Valid,
  output logic        o_Busy,
  output logic [7:0]  o_Harmonics_Used,
  output logic        o_Overrun
);

  localparam int unsigned SW = 16;
  localparam int unsigned CW = 17;
  localparam int unsigned PW = 33;

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_READY, S_SETTLE, S_MULT, S_ACCUM, S_NEXT, S_GAP, S_OUTPUT
  } state_e;

  state_e                  state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [SW-1:0]           amp_q, amp_d;
  logic [7:0]              count_q, count_d;
  logic signed [SW-1:0]    sample_q, sample_d;
  logic                    too_high_q, too_high_d;
  logic                    last_q, last_d;
  logic signed [CW-1:0]    contrib_q, contrib_d;
  logic [7:0]              harmonic_q, harmonic_d;
  logic                    next_sample_q, next_sample_d;
  logic [SW-1:0]           mix_out_q, mix_out_d;
  logic                    mix_valid_q, mix_valid_d;
  logic                    busy_q, busy_d;
  logic [7:0]              used_q, used_d;
  logic                    overrun_q, overrun_d;

  logic signed [ACC_W-1:0] shifted_c;
  logic [8:0]              limit_c;

  assign shifted_c = acc_q >>> OUT_SHIFT;
  // A harmonic count of zero still mixes one harmonic
  assign limit_c   = (i_Harmonic_Count == 8'd0) ? 9'd1 : {1'b0, i_Harmonic_Count};

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_q       <= S_IDLE;
      acc_q         <= '0;
      amp_q         <= 16'hFFFF;
      count_q       <= '0;
      sample_q      <= '0;
      too_high_q    <= 1'b0;
      last_q        <= 1'b0;
      contrib_q     <= '0;
      harmonic_q    <= '0;
      next_sample_q <= 1'b0;
      mix_out_q     <= '0;
      mix_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
      used_q        <= '0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      acc_q         <= acc_d;
      amp_q         <= amp_d;
      count_q       <= count_d;
      sample_q      <= sample_d;
      too_high_q    <= too_high_d;
      last_q        <= last_d;
      contrib_q     <= contrib_d;
      harmonic_q    <= harmonic_d;
      next_sample_q <= next_sample_d;
      mix_out_q     <= mix_out_d;
      mix_valid_q   <= mix_valid_d;
      busy_q        <= busy_d;
      used_q        <= used_d;
      overrun_q     <= overrun_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    acc_d         = acc_q;
    amp_d         = amp_q;
    count_d       = count_q;
    sample_d      = sample_q;
    too_high_d    = too_high_q;
    last_d        = last_q;
    contrib_d     = contrib_q;
    harmonic_d    = harmonic_q;
    next_sample_d = 1'b0;
    mix_out_d     = mix_out_q;
    mix_valid_d   = 1'b0;
    used_d        = used_q;
    overrun_d     = i_Start && (state_q != S_IDLE);

    unique case (state_q)
      S_IDLE: begin
        if (i_Start) begin
          acc_d   = '0;
          amp_d   = 16'hFFFF;
          count_d = '0;
          last_d  = 1'b0;
          state_d = S_WAIT_READY;
        end
      end
      S_WAIT_READY: begin
        if (i_Sample_Ready) state_d = S_SETTLE;
      end
      S_SETTLE: begin
        sample_d   = i_Sample_Value;
        too_high_d = i_Freq_Too_High;
        state_d    = S_MULT;
      end
      S_MULT: begin
        if (too_high_q) begin
          last_d  = 1'b1;
          state_d = S_NEXT;
        end else begin
          // Floor of sample * Q0.16 amplitude
          contrib_d = CW'((PW'(sample_q) * $signed({17'd0, amp_q})) >>> 16);
          amp_d     = SW'(({16'd0, amp_q} * {16'd0, i_Decay}) >> 16);
          state_d   = S_ACCUM;
        end
      end
      S_ACCUM: begin
        acc_d   = acc_q + ACC_W'(contrib_q);
        count_d = count_q + 8'd1;
        last_d  = (({1'b0, count_q} + 9'd1) >= limit_c) || (harmonic_q == 8'hFF);
        state_d = S_NEXT;
      end
      S_NEXT: begin
        next_sample_d = 1'b1;
        harmonic_d    = last_q ? 8'd0 : harmonic_q + 8'd1;
        state_d       = S_GAP;
      end
      S_GAP: begin
        // Producer ready lags the consume pulse by a cycle; ignore it here
        state_d = last_q ? S_OUTPUT : S_WAIT_READY;
      end
      S_OUTPUT: begin
        if ((&shifted_c[ACC_W-1:15]) || ~(|shifted_c[ACC_W-1:15]))
          mix_out_d = shifted_c[15:0];
        else
          mix_out_d = shifted_c[ACC_W-1] ? 16'h8000 : 16'h7FFF;
        used_d      = count_q;
        mix_valid_d = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  assign o_Harmonic       = harmonic_q;
  assign o_Next_Sample    = next_sample_q;
  assign o_Mix_Out        = mix_out_q;
  assign o_Mix_Valid      = mix_valid_q;
  assign o_Busy           = busy_q;
  assign o_Harmonics_Used = used_q;
  assign o_Overrun        = overrun_q;

endmodule

// File: tb/tb_harmonic_mixer.sv
// Self-checking bench for harmonic_mixer: a behavioural producer feeds per-harmonic
// samples, a reference model fills a scoreboard, and a monitor checks each frame.
module tb_harmonic_mixer;

  localparam int OUT_SHIFT = 2;

  typedef struct {
    int mix;
    int used;
    int pulses;
  } exp_t;

  logic        clk, rst_n, start;
  logic [7:0]  harm_cnt;
  logic [15:0] decay;
  logic        rdy;
  logic [15:0] samp_val;
  logic        too_high;
  logic [7:0]  o_harm;
  logic        o_ns, o_valid, o_busy, o_ovr;
  logic [15:0] o_mix;
  logic [7:0]  o_used;

  logic signed [15:0] samp [256];
  logic               th   [256];
  logic               hold_ready;
  int                 dly;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   valid_cnt = 0;
  int   frame_pulses = 0;
  logic prev_ns = 1'b0;

  harmonic_mixer dut (
    .i_Clock          (clk),
    .i_Reset_n        (rst_n),
    .i_Start          (start),
    .i_Harmonic_Count (harm_cnt),
    .i_Decay          (decay),
    .i_Sample_Ready   (rdy),
    .i_Sample_Value   (samp_val),
    .i_Freq_Too_High  (too_high),
    .o_Harmonic       (o_harm),
    .o_Next_Sample    (o_ns),
    .o_Mix_Out        (o_mix),
    .o_Mix_Valid      (o_valid),
    .o_Busy           (o_busy),
    .o_Harmonics_Used (o_used),
    .o_Overrun        (o_ovr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign samp_val = samp[o_harm];
  assign too_high = th[o_harm];

  // Producer: after a consume pulse, optionally drop ready for a few cycles
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy <= 1'b0;
      dly <= 0;
    end else if (o_ns) begin
      rdy <= hold_ready;
      dly <= int'($urandom_range(1, 3));
    end else if (!rdy) begin
      if (dly == 0) rdy <= 1'b1;
      else dly <= dly - 1;
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input int cnt, input int dec);
    exp_t   e;
    longint acc;
    longint amp;
    int     n;
    n = (cnt == 0) ? 1 : cnt;
    acc = 0;
    amp = 65535;
    e.used = 0;
    e.pulses = 0;
    for (int h = 0; h < 256; h++) begin
      e.pulses++;
      if (th[h]) break;
      acc += (longint'(samp[h]) * amp) >>> 16;
      amp = (amp * longint'(dec)) >> 16;
      e.used++;
      if (e.used >= n || h == 255) break;
    end
    acc = acc >>> OUT_SHIFT;
    if (acc > 32767) acc = 32767;
    if (acc < -32768) acc = -32768;
    e.mix = int'(acc);
    return e;
  endfunction

  // Monitor: consume-pulse spacing, index sequence and frame results
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      frame_pulses = 0;
      prev_ns = 1'b0;
    end else begin
      if (o_ns) begin
        chk("ns_back_to_back", int'(prev_ns), 0);
        frame_pulses++;
        if (sb.size() > 0)
          chk("harm_idx", int'(o_harm), (frame_pulses == sb[0].pulses) ? 0 : frame_pulses);
      end
      prev_ns = o_ns;
      if (o_valid) begin
        exp_t e;
        valid_cnt++;
        chk("sb_nonempty", sb.size(), 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("mix_out", int'($signed(o_mix)), e.mix);
          chk("harm_used", int'(o_used), e.used);
          chk("ns_pulses", frame_pulses, e.pulses);
          chk("harm_wrap", int'(o_harm), 0);
        end
        frame_pulses = 0;
      end
    end
  end

  task automatic begin_frame(input int cnt, input int dec);
    harm_cnt = 8'(cnt);
    decay    = 16'(dec);
    sb.push_back(model(cnt, dec));
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("busy", int'(o_busy), 1);
  endtask

  task automatic wait_valid(input int v0);
    int n;
    n = 0;
    while (valid_cnt == v0 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    chk("frame_done", int'(valid_cnt != v0), 1);
    @(posedge clk); #1;
  endtask

  task automatic run_frame(input int cnt, input int dec);
    int v0;
    v0 = valid_cnt;
    begin_frame(cnt, dec);
    wait_valid(v0);
  endtask

  task automatic fill(input int val);
    for (int i = 0; i < 256; i++) begin
      samp[i] = 16'(val);
      th[i]   = 1'b0;
    end
  endtask

  initial begin
    int v0;
    rst_n = 1'b0;
    start = 1'b0;
    harm_cnt = 8'd1;
    decay = 16'd0;
    hold_ready = 1'b1;
    fill(0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mix", int'(o_mix), 0);
    chk("rst_busy", int'(o_busy), 0);
    chk("rst_harm", int'(o_harm), 0);
    chk("rst_valid", int'(o_valid), 0);
    chk("rst_used", int'(o_used), 0);
    chk("rst_ns", int'(o_ns), 0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Ready held high throughout
    fill(16384);
    run_frame(1, 16'h1234);
    fill(8192);
    run_frame(3, 16'h8000);
    fill(32767);
    run_frame(8, 16'hFFFF);
    fill(-32768);
    run_frame(8, 16'hFFFF);
    fill(1000);
    run_frame(0, 16'hC000);
    fill(4000);
    th[2] = 1'b1;
    run_frame(4, 16'hE000);

    // Producer drops ready between harmonics, random content
    hold_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 256; i++) begin
        samp[i] = 16'($urandom);
        th[i]   = ($urandom_range(0, 15) == 0);
      end
      run_frame(int'($urandom_range(1, 12)), int'($urandom_range(0, 65535)));
    end
    fill(-300);
    run_frame(255, 16'hFFF0);

    // Start while busy: overrun pulse, frame result unaffected
    fill(12000);
    v0 = valid_cnt;
    begin_frame(5, 16'hA000);
    repeat (6) @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("overrun_pulse", int'(o_ovr), 1);
    @(negedge clk);
    chk("overrun_clear", int'(o_ovr), 0);
    wait_valid(v0);

    // Reset mid-frame: outputs clear at once, no result follows
    begin_frame(6, 16'hF000);
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_mix", int'(o_mix), 0);
    chk("arst_busy", int'(o_busy), 0);
    chk("arst_used", int'(o_used), 0);
    chk("arst_harm", int'(o_harm), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    v0 = valid_cnt;
    repeat (60) @(negedge clk);
    chk("arst_no_valid", valid_cnt, v0);
    chk("arst_idle", int'(o_busy), 0);
    @(posedge clk); #1;

    hold_ready = 1'b1;
    fill(8192);
    run_frame(3, 16'h8000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
